// File: rtl/signal_bounce_generator_pkg.sv
// Shared definitions for the bounce generator: FSM encoding, LFSR constants
// and the clamp helper used for the chatter draws.
`timescale 1ns/1ps
package signal_bounce_generator_pkg;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BOUNCE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/signal_bounce_generator_lfsr16.sv
// 16-bit Galois LFSR with a synchronous reset to a non-zero seed; shared by the
// MITM noise injectors.
`timescale 1ns/1ps
module lfsr16
  import signal_bounce_generator_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        sys_clk,
  input  logic        rst,
  output logic [15:0] q
);

  // An all-zero state would lock the register up, so a zero seed is promoted.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk) begin
    if (rst) q <= SEED_EFF;
    else     q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/signal_bounce_generator.sv
// Drives a requested logical level onto out_sig with LFSR-driven contact
// chatter followed by a guaranteed settle period.
`timescale 1ns/1ps
module signal_bounce_generator
  import signal_bounce_generator_pkg::*;
#(
  parameter int          BOUNCE_MAX_TOGGLES = 15,
  parameter int          TOGGLE_MAX_CYCLES  = 7,
  parameter int          SETTLE_CYCLES      = 32,
  parameter bit          IN_ACTIVE_LOW      = 1'b0,
  parameter bit          OUT_ACTIVE_LOW     = 1'b1,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic in_sig,
  input  logic bounce_en,
  output logic out_sig,
  output logic busy
);

  localparam int REM_W  = (BOUNCE_MAX_TOGGLES > 0) ? $clog2(BOUNCE_MAX_TOGGLES + 1) : 1;
  localparam int DCNT_W = $clog2(TOGGLE_MAX_CYCLES + 1);
  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [15:0]       lfsr_q;
  logic [1:0]        state;
  logic              lvl;
  logic              tgt;
  logic              tgt_q;
  logic [REM_W-1:0]  remaining;
  logic [DCNT_W-1:0] dcnt;
  logic [SCNT_W-1:0] scnt;
  logic [REM_W-1:0]  draw_n;
  logic [DCNT_W-1:0] draw_d;
  logic              unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .sys_clk (sys_clk),
    .rst     (rst),
    .q       (lfsr_q)
  );

  // Only the nibble and the 3-bit field feed the draws; the rest is spare.
  assign unused_lfsr_bits = ^{lfsr_q[15:11], lfsr_q[7:4]};

  assign tgt    = in_sig ^ IN_ACTIVE_LOW;
  assign draw_n = REM_W'(clamp(int'(lfsr_q[3:0]), BOUNCE_MAX_TOGGLES));
  assign draw_d = DCNT_W'(clamp(int'(lfsr_q[10:8]), TOGGLE_MAX_CYCLES - 1) + 1);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lvl       <= 1'b0;
      busy      <= 1'b0;
      tgt_q     <= 1'b0;
      remaining <= '0;
      dcnt      <= '0;
      scnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tgt != lvl) begin
            tgt_q <= tgt;
            busy  <= 1'b1;
            if (!bounce_en || draw_n == '0) begin
              lvl   <= tgt;
              scnt  <= SCNT_W'(SETTLE_CYCLES);
              state <= ST_SETTLE;
            end else begin
              remaining <= draw_n;
              dcnt      <= draw_d;
              state     <= ST_BOUNCE;
            end
          end
        end
        ST_BOUNCE: begin
          // Target is latched on entry, so input changes here are ignored.
          if (dcnt == DCNT_W'(1)) begin
            if (remaining != '0) begin
              lvl       <= ~lvl;
              remaining <= remaining - REM_W'(1);
              dcnt      <= draw_d;
            end else begin
              lvl   <= tgt_q;
              scnt  <= SCNT_W'(SETTLE_CYCLES);
              state <= ST_SETTLE;
            end
          end else begin
            dcnt <= dcnt - DCNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (scnt == SCNT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            scnt <= scnt - SCNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_sig = lvl ^ OUT_ACTIVE_LOW;

endmodule

// File: tb/tb_signal_bounce_generator.sv
// Self-checking bench: per-cycle comparison against a waveform-planning model
// plus directed reset, pass-through, chatter, lock-out and loopback scenarios.
`timescale 1ns/1ps
module tb_signal_bounce_generator;

  localparam int          MAXT   = 15;
  localparam int          TMAX   = 7;
  localparam int          SETTLE = 32;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          DEB_N  = 16;

  logic sys_clk = 1'b0;
  logic rst = 1'b1, in_sig = 1'b0, bounce_en = 1'b0;
  logic out_sig, busy;

  int checks = 0, failures = 0;
  int cyc = 0;

  signal_bounce_generator #(
    .BOUNCE_MAX_TOGGLES (MAXT),
    .TOGGLE_MAX_CYCLES  (TMAX),
    .SETTLE_CYCLES      (SETTLE),
    .IN_ACTIVE_LOW      (1'b0),
    .OUT_ACTIVE_LOW     (1'b1),
    .LFSR_SEED          (SEED)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .in_sig    (in_sig),
    .bounce_en (bounce_en),
    .out_sig   (out_sig),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: on each accepted transition the whole expected
  // (level, busy) trajectory is planned from the LFSR sequence.
  logic [15:0] m_lfsr = SEED;
  bit          m_lvl = 1'b0;
  bit          q_lvl[$];
  bit          q_busy[$];
  bit          exp_lvl = 1'b0, exp_busy = 1'b0;
  int          plan_edges = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int draw_n(input logic [15:0] l);
    int v = int'(l[3:0]);
    return (v > MAXT) ? MAXT : v;
  endfunction

  function automatic int draw_d(input logic [15:0] l);
    int v = int'(l[10:8]);
    return ((v > TMAX - 1) ? TMAX - 1 : v) + 1;
  endfunction

  task automatic push(input bit l, input bit b);
    if (q_lvl.size() > 0 ? (q_lvl[$] != l) : (m_lvl != l)) plan_edges++;
    q_lvl.push_back(l);
    q_busy.push_back(b);
  endtask

  task automatic plan(input logic [15:0] l0, input bit t, input bit en);
    logic [15:0] l = l0;
    bit lv = m_lvl;
    int rem = draw_n(l0);
    int d = draw_d(l0);
    plan_edges = 0;
    if (en && rem > 0) begin
      forever begin
        repeat (d) begin
          push(lv, 1'b1);
          l = lfsr_next(l);
        end
        if (rem == 0) break;
        lv = ~lv;
        rem--;
        d = draw_d(l);
      end
    end
    repeat (SETTLE) push(t, 1'b1);
    push(t, 1'b0);
    m_lvl = t;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_lfsr = SEED;
      m_lvl = 1'b0;
      q_lvl.delete();
      q_busy.delete();
      exp_lvl = 1'b0;
      exp_busy = 1'b0;
      return;
    end
    if (q_lvl.size() == 0 && in_sig != m_lvl) plan(m_lfsr, in_sig, bounce_en);
    if (q_lvl.size() > 0) begin
      exp_lvl  = q_lvl.pop_front();
      exp_busy = q_busy.pop_front();
    end else begin
      exp_lvl  = m_lvl;
      exp_busy = 1'b0;
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // Edge bookkeeping and a behavioural debouncer (active-low input) for loopback.
  logic prev_out = 1'b1;
  int   out_edges = 0;
  int   edge_times[$];
  bit   deb_on = 1'b0, deb = 1'b0;
  int   deb_cnt = 0, deb_flips = 0;

  task automatic cycle(input bit r, input bit i, input bit e);
    rst = r;
    in_sig = i;
    bounce_en = e;
    @(posedge sys_clk);
    model_edge();
    #1;
    cyc++;
    check("out_sig", out_sig, exp_lvl ^ 1'b1);
    check("busy", busy, exp_busy);
    if (out_sig != prev_out) begin
      out_edges++;
      edge_times.push_back(cyc);
    end
    prev_out = out_sig;
    if (deb_on) begin
      if (~out_sig != deb) begin
        deb_cnt++;
        if (deb_cnt == DEB_N) begin
          deb = ~out_sig;
          deb_cnt = 0;
          deb_flips++;
        end
      end else begin
        deb_cnt = 0;
      end
    end
  endtask

  task automatic run_until_idle(input bit i, input bit e);
    int n = 0;
    while (busy && n < 400) begin
      cycle(1'b0, i, e);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int bcnt;
    int prev;
    bit ri, re;

    // Reset held with a pending request.
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    check("rst_out", out_sig, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Pass-through: flips on the first edge, busy for exactly SETTLE cycles.
    cycle(1'b0, 1'b1, 1'b0);
    check("pass_busy_start", busy, 1'b1);
    check("pass_flip", out_sig, 1'b0);
    bcnt = 0;
    while (busy && bcnt < 100) begin
      bcnt++;
      cycle(1'b0, 1'b1, 1'b0);
    end
    check("pass_busy_len", bcnt, SETTLE);

    // Chatter straight out of reset, so the first draw comes from the seed.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    edge_times.delete();
    out_edges = 0;
    cycle(1'b0, 1'b1, 1'b1);
    prev = cyc;
    run_until_idle(1'b1, 1'b1);
    check("chatter_edges", out_edges, plan_edges);
    foreach (edge_times[k]) begin
      check("hold_range", ((edge_times[k] - prev) >= 1) && ((edge_times[k] - prev) <= TMAX), 1'b1);
      prev = edge_times[k];
    end
    check("chatter_final", out_sig, 1'b0);

    // Lock-out: request reverts mid-transition, restart one cycle after busy drops.
    cycle(1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    run_until_idle(1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("lockout_restart", busy, 1'b1);
    run_until_idle(1'b1, 1'b1);

    // Reset mid-transition aborts and reloads the seed.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    check("rst_mid_out", out_sig, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_lfsr", dut.u_lfsr.q, SEED);

    // Randomized traffic against the model.
    ri = 1'b0;
    re = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) ri = ~ri;
      if ($urandom_range(0, 7) == 0) re = ~re;
      cycle(($urandom_range(0, 499) == 0), ri, re);
    end
    run_until_idle(ri, re);

    // Loopback through a debouncer: 4 bouncy transitions give 4 clean ones.
    repeat (2) cycle(1'b1, 1'b0, 1'b1);
    deb_on = 1'b1;
    deb = 1'b0;
    deb_cnt = 0;
    deb_flips = 0;
    for (int k = 0; k < 4; k++) begin
      ri = (k % 2 == 0);
      cycle(1'b0, ri, 1'b1);
      run_until_idle(ri, 1'b1);
      repeat (4) cycle(1'b0, ri, 1'b1);
      check("loop_level", deb, ri);
    end
    check("loop_flips", deb_flips, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
